// File: rtl/inst_fetch_ram256x8.sv
// Instruction-fetch front end: 256-byte big-endian instruction RAM, program counter
// and IF/ID pipeline register with stall, branch redirect/flush and a debug read port.
module inst_fetch_ram256x8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_out,
    output logic [31:0] fetch_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    // Preloaded hierarchically by benches; no write port, untouched by reset.
    logic [7:0] Mem [0:255] = '{default: 8'h00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] fetch_word;
    logic [31:0] dbg_word;

    // Address bits above [7:0] never reach the RAM.
    logic unused_dbg_hi;
    assign unused_dbg_hi = ^dbg_addr[31:8];

    // Byte lane gi comes from A+gi (8-bit add wraps at 256), lane 0 is the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign fetch_word[31-8*gi -: 8] = Mem[pc_q[7:0] + 8'(gi)];
            assign dbg_word[31-8*gi -: 8]   = Mem[dbg_addr[7:0] + 8'(gi)];
        end
    endgenerate

    // Branch outranks stall; a flush inserts a zero bubble with valid low.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!hazard_stall) begin
            pc_d    = pc_q + 32'd4;
            instr_d = fetch_word;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign fetch_instr = fetch_word;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign dbg_data    = dbg_word;

endmodule

// File: tb/tb_inst_fetch_ram256x8.sv
// Scoreboard bench for inst_fetch_ram256x8: a reference model predicts the registers
// after each edge, expectations are queued at drive time and popped after the edge.
module tb_inst_fetch_ram256x8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] dbg_addr = 32'h0;
    logic [31:0] pc_out, fetch_instr, if_id_instr, if_id_pc4, dbg_data;
    logic        if_id_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [0:255];
    logic [31:0] pc_m = 32'h0, instr_m = 32'h0, pc4_m = 32'h0;
    logic        valid_m = 1'b0;

    inst_fetch_ram256x8 dut (
        .clk          (clk),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc_out       (pc_out),
        .fetch_instr  (fetch_instr),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_m(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = a[7:0];
        b1 = b0 + 8'd1;
        b2 = b0 + 8'd2;
        b3 = b0 + 8'd3;
        return {mem_m[b0], mem_m[b1], mem_m[b2], mem_m[b3]};
    endfunction

    task automatic poke(input int idx, input logic [7:0] val);
        mem_m[idx]   = val;
        dut.Mem[idx] = val;
    endtask

    // One clock: drive, check combinational ports, predict, then compare after the edge.
    task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] da;
        @(negedge clk);
        reset = rst; hazard_stall = st; branch_taken = br; branch_target = tgt;
        da = $urandom;
        dbg_addr = da;
        #1;
        check32("fetch_instr", fetch_instr, word_m(pc_m));
        check32("dbg_data", dbg_data, word_m(da));
        if (rst) begin
            pc_m = 32'h0; instr_m = 32'h0; pc4_m = 32'h0; valid_m = 1'b0;
        end else if (br) begin
            pc_m = tgt; instr_m = 32'h0; pc4_m = 32'h0; valid_m = 1'b0;
        end else if (!st) begin
            instr_m = word_m(pc_m); pc4_m = pc_m + 32'd4; valid_m = 1'b1; pc_m = pc_m + 32'd4;
        end
        e.pc = pc_m; e.instr = instr_m; e.pc4 = pc4_m; e.valid = valid_m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check32("pc_out", pc_out, e.pc);
        check32("if_id_instr", if_id_instr, e.instr);
        check32("if_id_pc4", if_id_pc4, e.pc4);
        check32("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
        $display("step rst=%0b st=%0b br=%0b tgt=%08h -> pc=%08h instr=%08h pc4=%08h v=%0b",
                 rst, st, br, tgt, pc_out, if_id_instr, if_id_pc4, if_id_valid);
    endtask

    initial begin
        logic [31:0] held_instr;
        logic [7:0]  pre [0:7];
        logic [31:0] a;

        #2;
        dbg_addr = 32'h10;
        #1;
        check32("mem_init_zero", dbg_data, 32'h0);

        for (int i = 0; i < 256; i++) poke(i, 8'($urandom));
        pre = '{8'hE3, 8'hA0, 8'h10, 8'h05, 8'hE2, 8'h81, 8'h20, 8'h01};
        for (int i = 0; i < 8; i++) poke(i, pre[i]);

        step(1'b1, 1'b0, 1'b0, 32'h0);
        check32("tp_fetch_after_reset", fetch_instr, 32'hE3A01005);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("tp_first_instr", if_id_instr, 32'hE3A01005);
        check32("tp_first_pc4", if_id_pc4, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("tp_second_instr", if_id_instr, 32'hE2812001);
        check32("tp_second_pc", pc_out, 32'd8);

        held_instr = if_id_instr;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check32("tp_stall_pc", pc_out, 32'd8);
        check32("tp_stall_instr", if_id_instr, held_instr);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("tp_release_pc", pc_out, 32'd12);

        step(1'b0, 1'b1, 1'b1, 32'h40);
        check32("tp_branch_pc", pc_out, 32'h40);
        check32("tp_branch_valid", {31'h0, if_id_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("tp_target_pc4", if_id_pc4, 32'h44);

        step(1'b0, 1'b0, 1'b1, 32'h1C);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("tp_pc_at_20", pc_out, 32'h20);
        step(1'b1, 1'b0, 1'b1, 32'h80);
        check32("tp_midreset_pc", pc_out, 32'h0);
        check32("tp_midreset_instr", if_id_instr, 32'h0);
        dbg_addr = 32'h0;
        #1;
        check32("tp_mem_kept", dbg_data, 32'hE3A01005);

        // PC wraps at 2^32 while memory indexing wraps at 256.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("pc_wrap", pc_out, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), a);
        end

        @(negedge clk);
        dbg_addr = 32'h1;
        #1;
        check32("tp_unaligned", dbg_data, 32'hA01005E2);
        poke(254, 8'hAA); poke(255, 8'hBB); poke(0, 8'hCC); poke(1, 8'hDD);
        dbg_addr = 32'hFE;
        #1;
        check32("tp_wrap_fe", dbg_data, 32'hAABBCCDD);
        dbg_addr = 32'h1FE;
        #1;
        check32("tp_wrap_1fe", dbg_data, 32'hAABBCCDD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
